// File: rtl/instr_fetch_if.sv
// Signal bundle between the fetch stage, instruction ROM port A, the redirect source and decode.
// The master modport is the fetch stage's view of the bundle.
interface instr_fetch_if;
   logic [31:0] memAddr;
   logic        memRequest;
   logic        memDone;
   logic [31:0] memData;
   logic        redirect;
   logic [31:0] redirectPc;
   logic        instValid;
   logic        instReady;
   logic [31:0] instData;
   logic [31:0] instPc;

   modport master (
      output memAddr, memRequest, instValid, instData, instPc,
      input  memDone, memData, redirect, redirectPc, instReady
   );

   modport slave (
      input  memAddr, memRequest, instValid, instData, instPc,
      output memDone, memData, redirect, redirectPc, instReady
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads to the ROM, and queues the
// one-cycle-latency responses for decode. A redirect flushes the queue and any in-flight read.
module instr_fetch #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic           clk,
   input logic           rst_n,
   instr_fetch_if.master bus
);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [31:0]            pc_q, pc_d;
   logic [DEPTH-1:0][31:0] data_q, data_d;
   logic [DEPTH-1:0][31:0] tag_q, tag_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW:0]            count_q, count_d;
   logic                   in_flight_q, in_flight_d;
   logic [31:0]            in_flight_pc_q, in_flight_pc_d;

   logic                   pop;
   logic                   push;
   logic                   accepted;
   logic                   mem_request;
   logic [PW+1:0]          committed;

   // Slots already spoken for once this cycle's pop leaves; a new read needs one to spare.
   assign pop         = (count_q != '0) & bus.instReady;
   assign push        = in_flight_q & ~bus.redirect;
   assign committed   = {1'b0, count_q}
                      + {{(PW+1){1'b0}}, in_flight_q}
                      - {{(PW+1){1'b0}}, pop};
   assign mem_request = rst_n & ~bus.redirect & (committed < (PW+2)'(DEPTH));
   assign accepted    = mem_request & bus.memDone;

   assign bus.memAddr    = pc_q;
   assign bus.memRequest = mem_request;
   assign bus.instValid  = (count_q != '0);
   assign bus.instData   = data_q[rd_ptr_q];
   assign bus.instPc     = tag_q[rd_ptr_q];

   always_comb begin
      pc_d           = pc_q;
      data_d         = data_q;
      tag_d          = tag_q;
      rd_ptr_d       = rd_ptr_q;
      wr_ptr_d       = wr_ptr_q;
      count_d        = count_q;
      in_flight_d    = 1'b0;
      in_flight_pc_d = in_flight_pc_q;

      if (bus.redirect) begin
         pc_d     = bus.redirectPc & ~32'd3;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            data_d[wr_ptr_q] = bus.memData;
            tag_d[wr_ptr_q]  = in_flight_pc_q;
            wr_ptr_d         = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
         if (accepted) begin
            in_flight_d    = 1'b1;
            in_flight_pc_d = pc_q;
            pc_d           = pc_q + 32'd4;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q           <= RESET_PC;
         data_q         <= '0;
         tag_q          <= '0;
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         count_q        <= '0;
         in_flight_q    <= 1'b0;
         in_flight_pc_q <= '0;
      end else begin
         pc_q           <= pc_d;
         data_q         <= data_d;
         tag_q          <= tag_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         count_q        <= count_d;
         in_flight_q    <= in_flight_d;
         in_flight_pc_q <= in_flight_pc_d;
      end
   end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits directly upstream of the instruction ROM port. It owns the program counter and issues word-aligned read requests to ROM port A. It captures the fixed one-cycle read data into a small instruction queue and presents instructions to decode with a valid/ready handshake. Branch/jump redirects flush the queue and discard any in-flight read.

## Interface
- DEPTH, 2: instruction queue entries; power of two, ≥2
- RESET_PC, 32'h00000000: PC loaded on reset; bits [1:0] must be 0

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low
- memAddr  out  32  ROM read address (= PC register)
- memRequest  out  1  read request to ROM
- memDone  in  1  ROM accepts request this cycle when high with memRequest
- memData  in  32  ROM read data, valid exactly one cycle after an accepted request
- redirect  in  1  one-cycle pulse: change fetch PC
- redirectPc  in  32  new PC; bits [1:0] ignored (forced 0)
- instValid  out  1  queue head valid
- instReady  in  1  decode accepts head
- instData  out  32  head instruction word
- instPc  out  32  PC of head instruction

## Operation
- State: pc, queue (DEPTH × {data, pc}), count, inFlight bit, inFlightPc.
- pop = instValid & instReady; accepted = memRequest & memDone.
- memRequest = !redirect & (count + inFlight − pop < DEPTH). Combinational from instReady; no path from memData.
- On accepted: inFlight←1, inFlightPc←pc, pc←pc+4 (mod 2^32, so 32'hFFFFFFFC wraps to 0). Else if no accept: inFlight←0, pc holds.
- memRequest high with memDone low: not accepted; pc holds, request re-presented next cycle.
- Response: in cycle after accept, if inFlight and no redirect, push {memData, inFlightPc}. Push and pop in the same cycle leave count unchanged. The credit rule guarantees no push when full.
- Redirect (cycle R): pc←{redirectPc[31:2],2'b00}; count←0; inFlight←0; memRequest low in R.
  - Any response arriving in R is dropped.
  - A pop in R completes normally; that instruction is consumed, the rest are flushed.
  - Back-to-back redirects: the last one wins.
- instValid = (count ≠ 0); instData/instPc = head entry. They are held stable while instValid & !instReady.
- No bypass: data enters decode only from the queue.

## Timing
- Reset values: memAddr = RESET_PC, memRequest = 0, instValid = 0, instData = 0, instPc = 0; count = 0, inFlight = 0.
- memRequest is forced low while rst_n is low. First request in the first cycle after rst_n rises, with memAddr = RESET_PC.
- Latency: request accepted in cycle N → memData sampled end of N+1 → instValid high in N+2.
- Throughput: with instReady=1 and memDone=1, one instruction per cycle sustained from N+2.
- Backpressure: with instReady=0, at most DEPTH requests are outstanding plus queued; then memRequest stays low until a pop.
- Redirect in R: first request to the new PC in R+1; its instruction appears at the earliest in R+3.
- Reset asserted mid-operation: all state cleared immediately (async); an in-flight response is never pushed.

## Test plan
- Reset release, RESET_PC=0, ROM words 0..15 = 0..15, instReady=1 → memAddr 0,4,8,… on consecutive cycles; instValid first high 2 cycles after release with instData=0/instPc=0, then 1/4, 2/8 back-to-back.
- instReady held low 10 cycles after reset → exactly 2 entries queued, memRequest low after 2 accepts, memAddr=8. Release ready → pops 0/0, 1/4, then 2/8 follows without gap.
- Redirect to 32'h00000023 while queue holds 2 entries and one read is in flight → queue empty next cycle, in-flight data discarded, memAddr=0x20 in R+1, instData=DATA8 with instPc=0x20 in R+3.
- Redirect in the same cycle as a pop of PC 0x10 → 0x10 consumed exactly once; no instruction from old stream after it.
- memDone low for 3 cycles at PC 0x0C → memRequest stays high with memAddr 0x0C; no push; resumes with 0x0C data after memDone rises.
- Redirect to 32'hFFFFFFFC → fetch addresses 0xFFFFFFFC then 0x00000000, instPc values match.
